// File: rtl/pipe_reg_execute_pkg.sv
// Shared definitions for the Decode->Execute pipeline register.
//   state_e   : stage state encoding reported on state_E
//   NOP_INSTR : instruction word loaded into a bubble (addi x0,x0,0)
//   *_DEF     : default widths and limits for the stage parameters
package pipe_reg_execute_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned CTRL_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned STALL_MAX_DEF = 15;

endpackage

// File: rtl/pipe_reg_execute_sat_counter.sv
// Saturating up-counter with async active-high reset.
//   clk, rst : clock, async active-high reset (clears q)
//   inc      : count up one, stops at MAX
//   clr      : sync clear, wins over inc
//   q        : count value
module sat_counter #(
  parameter int unsigned W   = 16,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_reg_execute.sv
// Decode->Execute pipeline register with hold, bubble insertion and
// stall/bubble performance counters plus a sticky stuck-stall flag.
//   clk, reset_E                : clock, async active-high stage reset
//   flush_E, stall_E, cnt_clr   : bubble next edge / hold next edge / clear counters
//   *_D                         : decoded instruction slot
//   *_E                         : registered copies for execute and hazard unit
//   state_E                     : RUN / HOLD / BUBBLE
//   stall_cnt, bubble_cnt       : saturating event counters
//   stall_timeout               : stall run reached STALL_MAX
module pipe_reg_execute
  import pipe_reg_execute_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_E,
  input  logic              flush_E,
  input  logic              stall_E,
  input  logic              cnt_clr,
  input  logic              valid_D,
  input  logic [XLEN-1:0]   pc_D,
  input  logic [31:0]       instr_D,
  input  logic [XLEN-1:0]   rs1_data_D,
  input  logic [XLEN-1:0]   rs2_data_D,
  input  logic [XLEN-1:0]   imm_D,
  input  logic [4:0]        rs3_D,
  input  logic              reg_WE_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  output logic              valid_E,
  output logic [XLEN-1:0]   pc_E,
  output logic [31:0]       instr_E,
  output logic [XLEN-1:0]   rs1_data_E,
  output logic [XLEN-1:0]   rs2_data_E,
  output logic [XLEN-1:0]   imm_E,
  output logic [4:0]        rs3_E,
  output logic              reg_WE_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [1:0]        state_E,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_timeout
);

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(STALL_MAX - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_load;
  logic              w_bubble;
  logic [CNT_W-1:0]  w_stall_run;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [31:0]       r_instr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs3;
  logic              r_reg_we;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_stall_timeout;

  // State register
  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) r_state <= ST_BUBBLE;
    else         r_state <= w_state_nxt;
  end

  // Next state depends only on the control inputs, never on the current state
  always_comb begin
    w_state_nxt = ST_BUBBLE;
    if (flush_E)      w_state_nxt = ST_BUBBLE;
    else if (stall_E) w_state_nxt = ST_HOLD;
    else if (valid_D) w_state_nxt = ST_RUN;
  end

  // Datapath controls decoded from the state being entered
  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    case (w_state_nxt)
      ST_RUN:    w_load   = 1'b1;
      ST_BUBBLE: w_bubble = 1'b1;
      default:   ;
    endcase
  end

  // Pipeline fields: bubble clears, load copies D, otherwise hold
  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_instr    <= NOP_INSTR;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs3      <= '0;
      r_reg_we   <= 1'b0;
      r_ctrl     <= '0;
    end else if (w_load) begin
      r_valid    <= valid_D;
      r_pc       <= pc_D;
      r_instr    <= instr_D;
      r_rs1_data <= rs1_data_D;
      r_rs2_data <= rs2_data_D;
      r_imm      <= imm_D;
      r_rs3      <= rs3_D;
      r_reg_we   <= reg_WE_D;
      r_ctrl     <= ctrl_D;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (reset_E),
    .inc (stall_E),
    .clr (cnt_clr),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (reset_E),
    .inc (w_bubble),
    .clr (cnt_clr),
    .q   (bubble_cnt)
  );

  // Consecutive-stall length; any non-stall edge ends the run
  sat_counter #(.W(CNT_W), .MAX(RUN_MAX)) u_stall_run (
    .clk (clk),
    .rst (reset_E),
    .inc (stall_E),
    .clr (cnt_clr | ~stall_E),
    .q   (w_stall_run)
  );

  // Sticky flag set on the edge the run length reaches STALL_MAX
  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) begin
      r_stall_timeout <= 1'b0;
    end else if (cnt_clr) begin
      r_stall_timeout <= 1'b0;
    end else if (stall_E && (w_stall_run == RUN_LAST)) begin
      r_stall_timeout <= 1'b1;
    end
  end

  assign valid_E       = r_valid;
  assign pc_E          = r_pc;
  assign instr_E       = r_instr;
  assign rs1_data_E    = r_rs1_data;
  assign rs2_data_E    = r_rs2_data;
  assign imm_E         = r_imm;
  assign rs3_E         = r_rs3;
  assign reg_WE_E      = r_reg_we;
  assign ctrl_E        = r_ctrl;
  assign state_E       = r_state;
  assign stall_timeout = r_stall_timeout;

endmodule
